streamcalc_stack: RTL and testbench
===================================

# streamcalc_stack

Parametrised RPN stream calculator: a LIFO operand stack of `DEPTH` entries, each `W` bits wide, driven by a valid/ready command stream. It performs the following operations on the top two entries:

- single-cycle add, subtract and multiply;
- multi-cycle divide and modulo, through a sequential divider.

It reports stack state and a sticky, encoded error. It is the next generation of the stream-calculator datapath and sits between the command source and any consumer of the top-of-stack value.

## Interface
- `W`, 8, operand/result width in bits (≥2)
- `DEPTH`, 8, stack entries (≥2)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  command present
- `in_ready`  out  1  block can accept a command this cycle
- `op`  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 PUSH, 6 POP, 7 DUP
- `in`  in  W  operand for PUSH, ignored otherwise
- `tail`  out  W  top-of-stack value, 0 when empty
- `count`  out  $clog2(DEPTH+1)  current number of entries
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `busy`  out  1  divider running
- `valid`  out  1  no error since reset
- `err`  out  2  first error since reset: 0 NONE, 1 DIVZERO, 2 UNDERFLOW, 3 OVERFLOW

## Operation
- A command is accepted on a rising edge with `in_valid && in_ready`.
- Operand naming: A = top, B = entry below top.
- Binary ops pop A and B, then push the result. Net count is −1.
  - ADD: A+B.
  - SUB: A−B.
  - MUL: A*B.
  - DIV: B/A (unsigned).
  - MOD: B%A (unsigned).
- All results are truncated to the low W bits (modular).
- PUSH pushes `in`. POP discards the top. DUP pushes a copy of A.
- Error checks happen at accept time. A failing command leaves the stack, `count` and `tail` unchanged and raises the error:
  - binary op with count<2 → UNDERFLOW;
  - POP or DUP with count==0 → UNDERFLOW;
  - PUSH or DUP with count==DEPTH → OVERFLOW;
  - DIV or MOD with A==0 and count≥2 → DIVZERO (underflow takes priority).
- Errors are sticky:
  - `valid` drops to 0 and stays 0 until `rst`;
  - `err` latches the first error only;
  - later commands continue to execute normally.
- Divider: restoring, one quotient bit per cycle.
  - Started on acceptance of a valid DIV or MOD.
  - While running: `busy`=1, `in_ready`=0, stack frozen.
- State machine has two states:
  - IDLE → DIV on accepted non-erroring DIV/MOD;
  - DIV → IDLE after W iterations, writing the quotient or remainder into the former B slot.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `count`=0, `empty`=1, `full`=0, `tail`=0, `valid`=1, `err`=0. Stack contents are cleared.
- ADD, SUB, MUL, PUSH, POP, DUP: result is visible on `tail` and `count` the cycle after accept. `in_ready` stays 1.
- DIV and MOD:
  - `busy` rises the cycle after accept and stays high for W cycles;
  - `in_ready` is low during those same cycles;
  - the result appears on `tail` in the cycle `busy` falls, which is W+1 cycles after accept;
  - a new command can be accepted in that same cycle.
- An erroring command still costs only one cycle. `valid` and `err` update the cycle after accept.
- All outputs are registered; no combinational path from `in_valid` to `in_ready`.
- `rst` has priority over everything. Reset mid-division aborts the divider and returns to IDLE with reset values next cycle.
- `in_valid` while `in_ready`=0 is ignored (not queued). The source must hold the command.

## Structure
- Package `streamcalc_pkg`:
  - opcode constants OP_ADD..OP_DUP;
  - error codes ERR_NONE, ERR_DIVZERO, ERR_UNDERFLOW, ERR_OVERFLOW;
  - FSM state type.
- Sub-module `seq_divider`:
  - parameter W;
  - inputs `clk`, `rst`, `start`, `dividend`, `divisor`;
  - outputs `busy`, `done` (1-cycle pulse), `quotient`, `remainder`.
- Stack is a register array plus a count pointer; `tail` is registered from the top entry.

## Test plan
- W=8, DEPTH=4, reset → `count`=0, `empty`=1, `tail`=0, `valid`=1, `err`=0, `in_ready`=1.
- PUSH 200, PUSH 100, ADD → `tail`=44, `count`=1. Then PUSH 5, SUB → `tail`=5−44=217, `count`=1.
- PUSH 7, PUSH 3, DIV:
  - `busy` and `!in_ready` for exactly 8 cycles;
  - then `tail`=2, `count`=1;
  - repeat with MOD → `tail`=1.
- PUSH 5, PUSH 0, DIV → `count`=2, `tail`=0, `valid`=0, `err`=1, `busy` never set. A following PUSH 9 is still accepted.
- Five PUSHes at DEPTH=4 → fifth ignored, `full`=1, `err`=3. Then 4 POPs plus 1 extra POP → `empty`=1, `err` stays 3.
- Assert `rst` 3 cycles into a DIV → next cycle all reset values, `in_ready`=1. A subsequent PUSH 1 gives `tail`=1.

Source files
------------

// File: rtl/streamcalc_pkg.sv
// Shared opcodes, error codes and FSM state type for the RPN stream calculator.
package streamcalc_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_MOD  = 3'd4;
    localparam logic [2:0] OP_PUSH = 3'd5;
    localparam logic [2:0] OP_POP  = 3'd6;
    localparam logic [2:0] OP_DUP  = 3'd7;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_DIVZERO   = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_e;

endpackage

// File: rtl/streamcalc_stack_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so the result lands W edges after start.
module seq_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  rem_in, quo_in, dvs_in;
    logic [W:0]    shifted, diff;
    logic          qbit;

    // One restoring step, fed from the operands directly on the start edge.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_in  = start ? divisor : dvs_q;
        shifted = {rem_in, quo_in[W-1]};
        diff    = shifted - {1'b0, dvs_in};
        qbit    = 1'b0;
        rem_d   = shifted[W-1:0];
        if (shifted >= {1'b0, dvs_in}) begin
            qbit  = 1'b1;
            rem_d = diff[W-1:0];
        end
        quo_d = {quo_in[W-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= divisor;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/streamcalc_stack.sv
// RPN stream calculator: register-array LIFO with valid/ready command input,
// single-cycle ALU ops, sequential DIV/MOD and a sticky first-error report.
module streamcalc_stack
    import streamcalc_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op,
    input  logic [W-1:0]                 in,
    output logic [W-1:0]                 tail,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         busy,
    output logic                         valid,
    output logic [1:0]                   err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e        state_q, state_d;
    logic [W-1:0]  stack_q [DEPTH];
    logic [W-1:0]  stack_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  tail_q, tail_d;
    logic          valid_q, valid_d;
    logic [1:0]    err_q, err_d;
    logic          is_mod_q, is_mod_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;

    logic [IW-1:0] top_idx, sec_idx, push_idx;
    logic [W-1:0]  a_c, b_c, res_c;
    logic [1:0]    err_c;
    logic          accept_c;
    logic          div_start_c;
    logic          div_busy, div_done;
    logic [W-1:0]  div_quo, div_rem;

    assign top_idx  = IW'(count_q - CW'(1));
    assign sec_idx  = IW'(count_q - CW'(2));
    assign push_idx = IW'(count_q);
    assign a_c      = stack_q[top_idx];
    assign b_c      = stack_q[sec_idx];
    assign accept_c = in_valid && in_ready_q && !div_busy;

    // Accept-time error classification; underflow outranks divide-by-zero.
    always_comb begin
        err_c = ERR_NONE;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: begin
                if (count_q < CW'(2)) err_c = ERR_UNDERFLOW;
            end
            OP_DIV, OP_MOD: begin
                if (count_q < CW'(2))  err_c = ERR_UNDERFLOW;
                else if (a_c == '0)    err_c = ERR_DIVZERO;
            end
            OP_PUSH: begin
                if (count_q == CW'(DEPTH)) err_c = ERR_OVERFLOW;
            end
            OP_POP: begin
                if (count_q == '0) err_c = ERR_UNDERFLOW;
            end
            default: begin
                if (count_q == '0)              err_c = ERR_UNDERFLOW;
                else if (count_q == CW'(DEPTH)) err_c = ERR_OVERFLOW;
            end
        endcase
    end

    // Next-state, stack update and output pre-computation.
    always_comb begin
        state_d     = state_q;
        stack_d     = stack_q;
        count_d     = count_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        err_d       = err_q;
        is_mod_d    = is_mod_q;
        div_start_c = 1'b0;
        res_c       = is_mod_q ? div_rem : div_quo;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (err_c != ERR_NONE) begin
                        if (valid_q) begin
                            valid_d = 1'b0;
                            err_d   = err_c;
                        end
                    end else begin
                        case (op)
                            OP_ADD, OP_SUB, OP_MUL: begin
                                if (op == OP_ADD)      tail_d = a_c + b_c;
                                else if (op == OP_SUB) tail_d = a_c - b_c;
                                else                   tail_d = W'(a_c * b_c);
                                stack_d[sec_idx] = tail_d;
                                count_d          = count_q - CW'(1);
                            end
                            OP_DIV, OP_MOD: begin
                                div_start_c = 1'b1;
                                is_mod_d    = (op == OP_MOD);
                                state_d     = S_DIV;
                            end
                            OP_PUSH: begin
                                stack_d[push_idx] = in;
                                count_d           = count_q + CW'(1);
                                tail_d            = in;
                            end
                            OP_POP: begin
                                count_d = count_q - CW'(1);
                                tail_d  = (count_q >= CW'(2)) ? b_c : '0;
                            end
                            default: begin
                                stack_d[push_idx] = a_c;
                                count_d           = count_q + CW'(1);
                                tail_d            = a_c;
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (div_done) begin
                    stack_d[sec_idx] = res_c;
                    count_d          = count_q - CW'(1);
                    tail_d           = res_c;
                    state_d          = S_IDLE;
                end
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_DIV);
        empty_d    = (count_d == '0);
        full_d     = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            count_q    <= '0;
            tail_q     <= '0;
            valid_q    <= 1'b1;
            err_q      <= ERR_NONE;
            is_mod_q   <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stack_q    <= stack_d;
            count_q    <= count_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            is_mod_q   <= is_mod_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
        end
    end

    seq_divider #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_c),
        .dividend  (b_c),
        .divisor   (a_c),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign in_ready = in_ready_q;
    assign tail     = tail_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_streamcalc_stack.sv
// Scoreboard bench for streamcalc_stack (W=8, DEPTH=4): the driver queues the
// expected post-command state, a monitor pops and compares when results appear.
module tb_streamcalc_stack;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
                           MOD = 3'd4, PSH = 3'd5, POP = 3'd6, DUP = 3'd7;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [2:0]    op       = 3'd0;
    logic [W-1:0]  din      = '0;
    logic          in_ready;
    logic [W-1:0]  tail;
    logic [CW-1:0] count;
    logic          empty, full, busy, valid;
    logic [1:0]    err;

    always #5 clk = ~clk;

    streamcalc_stack #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .in       (din),
        .tail     (tail),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .busy     (busy),
        .valid    (valid),
        .err      (err)
    );

    typedef struct packed {
        logic [7:0] tail;
        logic [7:0] count;
        logic       empty;
        logic       full;
        logic       valid;
        logic [1:0] err;
        logic [7:0] busy_cycles;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    chk_req  = 0;
    int    chk_done = 0;
    bit    pend     = 1'b0;
    int    busy_cnt = 0;

    task automatic check(input string nm, input string fld, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, expv);
        end
    endtask

    task automatic compare(input bit with_bc, input int bc);
        exp_t  e;
        string nm;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output tail=%0d count=%0d", tail, count);
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, "tail",     int'(tail),     int'(e.tail));
        check(nm, "count",    int'(count),    int'(e.count));
        check(nm, "empty",    int'(empty),    int'(e.empty));
        check(nm, "full",     int'(full),     int'(e.full));
        check(nm, "valid",    int'(valid),    int'(e.valid));
        check(nm, "err",      int'(err),      int'(e.err));
        check(nm, "in_ready", int'(in_ready), 1);
        check(nm, "busy",     int'(busy),     0);
        if (with_bc) check(nm, "busy_cycles", bc, int'(e.busy_cycles));
    endtask

    // Track acceptance at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            pend     = 1'b0;
            busy_cnt = 0;
        end else if (in_valid && in_ready) begin
            pend     = 1'b1;
            busy_cnt = 0;
        end
    end

    // Compare once the accepted command's result is presented.
    always @(negedge clk) begin
        if (chk_req != chk_done) begin
            chk_done++;
            compare(1'b0, 0);
        end else if (pend) begin
            if (busy) begin
                busy_cnt++;
                if (busy_cnt > 64) begin
                    checks++;
                    failures++;
                    $display("FAIL busy_timeout cycles=%0d limit=64", busy_cnt);
                    pend = 1'b0;
                end
            end else begin
                pend = 1'b0;
                compare(1'b1, busy_cnt);
            end
        end
    end

    function automatic exp_t mk(input int t, input int c, input bit v, input int e, input int bc);
        exp_t x;
        x.tail        = 8'(t);
        x.count       = 8'(c);
        x.empty       = (c == 0);
        x.full        = (c == DEPTH);
        x.valid       = v;
        x.err         = 2'(e);
        x.busy_cycles = 8'(bc);
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic cmd(input string nm, input logic [2:0] o, input int v, input bit exp_it,
                       input int t, input int c, input bit vld, input int e, input int bc);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s.ready_timeout in_ready=%0d required=1", nm, in_ready);
            return;
        end
        if (exp_it) begin
            exp_q.push_back(mk(t, c, vld, e, bc));
            name_q.push_back(nm);
        end
        op       = o;
        din      = W'(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 1'b1, 0, 0));
        name_q.push_back(nm);
        chk_req++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset("reset0");

        cmd("push200", PSH, 200, 1, 200, 1, 1, 0, 0);
        cmd("push100", PSH, 100, 1, 100, 2, 1, 0, 0);
        cmd("add",     ADD, 0,   1, 44,  1, 1, 0, 0);
        cmd("push5",   PSH, 5,   1, 5,   2, 1, 0, 0);
        cmd("sub",     SUB, 0,   1, 217, 1, 1, 0, 0);
        cmd("pop_a",   POP, 0,   1, 0,   0, 1, 0, 0);

        cmd("push7",   PSH, 7,   1, 7,   1, 1, 0, 0);
        cmd("push3",   PSH, 3,   1, 3,   2, 1, 0, 0);
        cmd("div7_3",  DIV, 0,   1, 2,   1, 1, 0, 8);
        cmd("pop_b",   POP, 0,   1, 0,   0, 1, 0, 0);
        cmd("push7b",  PSH, 7,   1, 7,   1, 1, 0, 0);
        cmd("push3b",  PSH, 3,   1, 3,   2, 1, 0, 0);
        cmd("mod7_3",  MOD, 0,   1, 1,   1, 1, 0, 8);
        cmd("pop_c",   POP, 0,   1, 0,   0, 1, 0, 0);

        cmd("push5z",  PSH, 5,   1, 5,   1, 1, 0, 0);
        cmd("push0",   PSH, 0,   1, 0,   2, 1, 0, 0);
        cmd("divzero", DIV, 0,   1, 0,   2, 0, 1, 0);
        cmd("push9",   PSH, 9,   1, 9,   3, 0, 1, 0);

        do_reset("reset1");
        cmd("fill1",   PSH, 1,   1, 1,   1, 1, 0, 0);
        cmd("fill2",   PSH, 2,   1, 2,   2, 1, 0, 0);
        cmd("fill3",   PSH, 3,   1, 3,   3, 1, 0, 0);
        cmd("fill4",   PSH, 4,   1, 4,   4, 1, 0, 0);
        cmd("ovf",     PSH, 5,   1, 4,   4, 0, 3, 0);
        cmd("drain3",  POP, 0,   1, 3,   3, 0, 3, 0);
        cmd("drain2",  POP, 0,   1, 2,   2, 0, 3, 0);
        cmd("drain1",  POP, 0,   1, 1,   1, 0, 3, 0);
        cmd("drain0",  POP, 0,   1, 0,   0, 0, 3, 0);
        cmd("unf_pop", POP, 0,   1, 0,   0, 0, 3, 0);

        do_reset("reset2");
        cmd("push6",   PSH, 6,   1, 6,   1, 1, 0, 0);
        cmd("dup6",    DUP, 0,   1, 6,   2, 1, 0, 0);
        cmd("mul",     MUL, 0,   1, 36,  1, 1, 0, 0);
        cmd("unf_add", ADD, 0,   1, 36,  1, 0, 2, 0);
        cmd("push200b",PSH, 200, 1, 200, 2, 0, 2, 0);
        cmd("push7c",  PSH, 7,   1, 7,   3, 0, 2, 0);
        cmd("div200_7",DIV, 0,   1, 28,  2, 0, 2, 8);
        cmd("mod36_28",MOD, 0,   1, 8,   1, 0, 2, 8);
        cmd("dup_a",   DUP, 0,   1, 8,   2, 0, 2, 0);
        cmd("dup_b",   DUP, 0,   1, 8,   3, 0, 2, 0);
        cmd("dup_c",   DUP, 0,   1, 8,   4, 0, 2, 0);
        cmd("dup_ovf", DUP, 0,   1, 8,   4, 0, 2, 0);

        do_reset("reset3");
        cmd("push7d",  PSH, 7,   1, 7,   1, 1, 0, 0);
        cmd("push3d",  PSH, 3,   1, 3,   2, 1, 0, 0);
        cmd("div_abrt",DIV, 0,   0, 0,   0, 1, 0, 0);
        repeat (2) @(negedge clk);
        do_reset("reset_middiv");
        cmd("push1",   PSH, 1,   1, 1,   1, 1, 0, 0);

        repeat (4) @(negedge clk);
        check("end", "queue_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
